// File: rtl/rv_iopmp_pkg.sv
// rv_iopmp_pkg: shared IOPMP violation-record types and helpers
package rv_iopmp_pkg;

    localparam int ADDR_WIDTH     = 64;
    localparam int SID_WIDTH      = 8;
    localparam int NUMBER_ENTRIES = 8;
    localparam int EID_WIDTH      = $clog2(NUMBER_ENTRIES);

    typedef enum logic [2:0] {
        ETYPE_NONE,
        ETYPE_ILLEGAL_READ,
        ETYPE_ILLEGAL_WRITE,
        ETYPE_NOT_HIT,
        ETYPE_PARTIAL_HIT
    } etype_e;

    typedef enum logic [1:0] {
        TTYPE_NONE,
        TTYPE_READ,
        TTYPE_WRITE,
        TTYPE_EXEC
    } ttype_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [SID_WIDTH-1:0]  sid;
        logic [EID_WIDTH-1:0]  eid;
        etype_e                etype;
        ttype_e                ttype;
    } err_record_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rv_iopmp_err_rr_arb.sv
// rv_iopmp_err_rr_arb: round-robin arbiter over N requesters
// Ports: clk_i/rst_i clock and async reset; valid_i request vector;
// grant_o one-hot grant; idx_o winner index; any_o some request present.
// Every request is accepted on the cycle it wins, so the pointer moves
// to winner+1 whenever any request is present.
module rv_iopmp_err_rr_arb #(
    parameter int N  = 1,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [N-1:0]  valid_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] j;

    always_comb begin
        grant_o = '0;
        idx_o   = ptr_q;
        any_o   = 1'b0;
        j       = '0;
        // Scan from the pointer upward, wrapping; first hit wins.
        for (int k = 0; k < N; k++) begin
            j = IW'((int'(ptr_q) + k) % N);
            if (!any_o && valid_i[j]) begin
                any_o = 1'b1;
                idx_o = j;
            end
        end
        if (any_o) grant_o[idx_o] = 1'b1;
        ptr_d = any_o ? IW'((int'(idx_o) + 1) % N) : ptr_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/rv_iopmp_err_fifo.sv
// rv_iopmp_err_fifo: arbitrated capture of IOPMP violation records into a FIFO
// Ports: err_valid_i/err_ready_o/err_record_i per-instance report handshake;
// enable_i capture enable; intr_en_i interrupt enable; pop_i drop head;
// clr_ovf_i clear overflow and drop count; head_valid_o/head_record_o/count_o
// FIFO view; overflow_o/drop_cnt_o drop tracking; wsi_o registered interrupt.
module rv_iopmp_err_fifo
    import rv_iopmp_pkg::*;
#(
    parameter int NUMBER_TL_INSTANCES = 1,
    parameter int FIFO_DEPTH          = 4,
    parameter int CW = $clog2(FIFO_DEPTH + 1),
    parameter int PW = $clog2(FIFO_DEPTH),
    parameter int IW = (NUMBER_TL_INSTANCES > 1) ? $clog2(NUMBER_TL_INSTANCES) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NUMBER_TL_INSTANCES-1:0]      err_valid_i,
    output logic [NUMBER_TL_INSTANCES-1:0]      err_ready_o,
    input  err_record_t [NUMBER_TL_INSTANCES-1:0] err_record_i,
    input  logic                                enable_i,
    input  logic                                intr_en_i,
    input  logic                                pop_i,
    input  logic                                clr_ovf_i,
    output logic                                head_valid_o,
    output err_record_t                         head_record_o,
    output logic [CW-1:0]                       count_o,
    output logic                                overflow_o,
    output logic [15:0]                         drop_cnt_o,
    output logic                                wsi_o
);

    logic [NUMBER_TL_INSTANCES-1:0] grant;
    logic [IW-1:0]                  idx;
    logic                           any;

    err_record_t   mem_q [FIFO_DEPTH];
    err_record_t   mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d, wsi_q, wsi_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;
    logic          do_pop, do_push, push_try, full, drop;

    rv_iopmp_err_rr_arb #(.N(NUMBER_TL_INSTANCES), .IW(IW)) u_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (err_valid_i),
        .grant_o (grant),
        .idx_o   (idx),
        .any_o   (any)
    );

    // Grants are suppressed while in reset so no handshake can complete.
    assign err_ready_o   = rst_i ? '0 : grant;
    assign head_valid_o  = count_q != '0;
    assign head_record_o = head_valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o       = count_q;
    assign overflow_o    = overflow_q;
    assign drop_cnt_o    = drop_cnt_q;
    assign wsi_o         = wsi_q;

    always_comb begin
        do_pop   = pop_i & head_valid_o;
        push_try = any & enable_i;
        full     = count_q == CW'(FIFO_DEPTH);
        // A pop in the same cycle frees the slot the push needs.
        do_push  = push_try & (~full | do_pop);
        drop     = push_try & full & ~do_pop;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        mem_d    = mem_q;
        if (do_push) mem_d[wr_ptr_q] = err_record_i[idx];
        // A drop coinciding with a clear still records itself.
        overflow_d = drop | (overflow_q & ~clr_ovf_i);
        drop_cnt_d = drop ? (clr_ovf_i ? 16'd1 : sat_inc16(drop_cnt_q))
                          : (clr_ovf_i ? 16'd0 : drop_cnt_q);
        wsi_d      = intr_en_i & ((count_d != '0) | overflow_d);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            wsi_q      <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            wsi_q      <= wsi_d;
        end
    end

endmodule

// File: tb/tb_rv_iopmp_err_fifo.sv
// tb_rv_iopmp_err_fifo: scoreboard bench for the violation-record FIFO
module tb_rv_iopmp_err_fifo;
    import rv_iopmp_pkg::*;

    localparam int NI = 3;
    localparam int FD = 4;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [NI-1:0]     err_valid_i;
    logic [NI-1:0]     err_ready_o;
    err_record_t [NI-1:0] recs;
    logic              enable_i, intr_en_i, pop_i, clr_ovf_i;
    logic              head_valid_o;
    err_record_t       head_record_o;
    logic [2:0]        count_o;
    logic              overflow_o;
    logic [15:0]       drop_cnt_o;
    logic              wsi_o;

    int          checks = 0;
    int          failures = 0;
    err_record_t q[$];
    bit          m_ovf;
    logic [15:0] m_drop;
    int          rr;
    int          seq;

    always #5 clk_i = ~clk_i;

    rv_iopmp_err_fifo #(.NUMBER_TL_INSTANCES(NI), .FIFO_DEPTH(FD)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .err_valid_i   (err_valid_i),
        .err_ready_o   (err_ready_o),
        .err_record_i  (recs),
        .enable_i      (enable_i),
        .intr_en_i     (intr_en_i),
        .pop_i         (pop_i),
        .clr_ovf_i     (clr_ovf_i),
        .head_valid_o  (head_valid_o),
        .head_record_o (head_record_o),
        .count_o       (count_o),
        .overflow_o    (overflow_o),
        .drop_cnt_o    (drop_cnt_o),
        .wsi_o         (wsi_o)
    );

    function automatic err_record_t mk_rec(input int inst, input int s);
        err_record_t r;
        r.addr  = 64'h8000_1000 + 64'(s) * 64'h40;
        r.sid   = 8'(3 + inst);
        r.eid   = 3'(s);
        r.etype = etype_e'(3'(1 + s % 4));
        r.ttype = ttype_e'(2'(s % 4));
        return r;
    endfunction

    // One clock of stimulus: checks the combinational grant and the popped
    // head before the edge, updates the model, then checks all state after.
    task automatic step(input logic [NI-1:0] v, input logic p, input logic c, input string tag);
        logic [NI-1:0] er;
        err_record_t   he;
        int            win;
        bit            drop;
        err_valid_i = v;
        pop_i       = p;
        clr_ovf_i   = c;
        #1;
        win = -1;
        for (int k = 0; k < NI; k++)
            if (win < 0 && v[(rr + k) % NI]) win = (rr + k) % NI;
        er = (win >= 0) ? (NI'(1) << win) : '0;
        checks++;
        if (err_ready_o !== er) begin
            failures++;
            $display("FAIL %s ready got=%b exp=%b", tag, err_ready_o, er);
        end
        if (p && q.size() > 0) begin
            checks++;
            if (head_record_o !== q[0]) begin
                failures++;
                $display("FAIL %s pop_head got=%h exp=%h", tag, head_record_o, q[0]);
            end
            void'(q.pop_front());
        end
        drop = 0;
        if (win >= 0 && enable_i) begin
            if (q.size() < FD) q.push_back(recs[win]);
            else drop = 1;
        end
        if (c) begin
            m_ovf  = 0;
            m_drop = 0;
        end
        if (drop) begin
            m_ovf  = 1;
            m_drop = (m_drop == 16'hFFFF) ? m_drop : m_drop + 16'd1;
        end
        @(posedge clk_i);
        #1;
        if (win >= 0) begin
            rr = (win + 1) % NI;
            seq++;
            recs[win] = mk_rec(win, seq);
        end
        err_valid_i = '0;
        pop_i       = 0;
        clr_ovf_i   = 0;
        he = (q.size() > 0) ? q[0] : '0;
        checks += 6;
        if (count_o !== 3'(q.size())) begin
            failures++;
            $display("FAIL %s count got=%0d exp=%0d", tag, count_o, q.size());
        end
        if (head_valid_o !== (q.size() > 0)) begin
            failures++;
            $display("FAIL %s head_valid got=%b exp=%b", tag, head_valid_o, q.size() > 0);
        end
        if (head_record_o !== he) begin
            failures++;
            $display("FAIL %s head got=%h exp=%h", tag, head_record_o, he);
        end
        if (overflow_o !== m_ovf) begin
            failures++;
            $display("FAIL %s overflow got=%b exp=%b", tag, overflow_o, m_ovf);
        end
        if (drop_cnt_o !== m_drop) begin
            failures++;
            $display("FAIL %s drop_cnt got=%h exp=%h", tag, drop_cnt_o, m_drop);
        end
        if (wsi_o !== (intr_en_i & (q.size() > 0 || m_ovf))) begin
            failures++;
            $display("FAIL %s wsi got=%b exp=%b", tag, wsi_o, intr_en_i & (q.size() > 0 || m_ovf));
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf  = 0;
        m_drop = 0;
        rr     = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks += 7;
        if (err_ready_o !== '0)   begin failures++; $display("FAIL %s ready got=%b exp=0", tag, err_ready_o); end
        if (head_valid_o !== 1'b0) begin failures++; $display("FAIL %s head_valid got=%b exp=0", tag, head_valid_o); end
        if (head_record_o !== '0) begin failures++; $display("FAIL %s head got=%h exp=0", tag, head_record_o); end
        if (count_o !== 3'd0)     begin failures++; $display("FAIL %s count got=%0d exp=0", tag, count_o); end
        if (overflow_o !== 1'b0)  begin failures++; $display("FAIL %s overflow got=%b exp=0", tag, overflow_o); end
        if (drop_cnt_o !== 16'd0) begin failures++; $display("FAIL %s drop_cnt got=%h exp=0", tag, drop_cnt_o); end
        if (wsi_o !== 1'b0)       begin failures++; $display("FAIL %s wsi got=%b exp=0", tag, wsi_o); end
    endtask

    task automatic drain(input string tag);
        while (q.size() > 0) step('0, 1, 0, tag);
    endtask

    task automatic test_reset();
        rst_i = 1;
        repeat (2) @(posedge clk_i);
        #1;
        check_reset_outputs("reset");
        rst_i = 0;
        model_reset();
    endtask

    task automatic test_single();
        step(3'b001, 0, 0, "single_push");
        checks++;
        if (head_record_o.addr !== 64'h8000_1000 || head_record_o.sid !== 8'd3) begin
            failures++;
            $display("FAIL single_fields got=%h/%h exp=80001000/03", head_record_o.addr, head_record_o.sid);
        end
        step('0, 1, 0, "single_pop");
    endtask

    task automatic test_fill();
        for (int i = 0; i < 5; i++) step(3'b001, 0, 0, "fill");
        checks++;
        if (overflow_o !== 1'b1 || drop_cnt_o !== 16'd1 || count_o !== 3'd4) begin
            failures++;
            $display("FAIL fill_end got=%b/%0d/%0d exp=1/1/4", overflow_o, drop_cnt_o, count_o);
        end
        step('0, 0, 1, "fill_clr");
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 3; i++) step(3'b001, 1, 0, "full_push_pop");
        step(3'b001, 1, 1, "full_push_pop_clr");
        drain("full_drain");
    endtask

    task automatic test_rr();
        for (int i = 0; i < 9; i++) step(3'b111, 1, 0, "rr_flow");
        for (int i = 0; i < 4; i++) step(3'b101, 0, 0, "rr_partial");
        drain("rr_drain");
        step('0, 0, 1, "rr_clr");
    endtask

    task automatic test_disable();
        enable_i = 0;
        for (int i = 0; i < 4; i++) step(3'b011, 0, 0, "disabled");
        enable_i = 1;
    endtask

    task automatic test_saturate();
        for (int i = 0; i < FD; i++) step(3'b001, 0, 0, "sat_fill");
        for (int i = 0; i < 32'h10000; i++) step(3'b001, 0, 0, "sat_drop");
        checks++;
        if (drop_cnt_o !== 16'hFFFF) begin
            failures++;
            $display("FAIL saturate got=%h exp=ffff", drop_cnt_o);
        end
        step(3'b001, 0, 1, "sat_clr_with_drop");
        step('0, 0, 1, "sat_clr");
        drain("sat_drain");
    endtask

    task automatic test_rst_mid();
        for (int i = 0; i < 3; i++) step(3'b001, 0, 0, "pre_rst");
        err_valid_i = 3'b111;
        #2;
        rst_i = 1;
        #1;
        check_reset_outputs("mid_reset");
        model_reset();
        @(posedge clk_i);
        #1;
        rst_i = 0;
        step(3'b010, 0, 0, "post_rst");
        drain("post_rst_drain");
    endtask

    initial begin
        rst_i       = 1;
        err_valid_i = '0;
        enable_i    = 1;
        intr_en_i   = 1;
        pop_i       = 0;
        clr_ovf_i   = 0;
        for (int i = 0; i < NI; i++) recs[i] = mk_rec(i, i);
        seq = NI - 1;
        model_reset();
        test_reset();
        test_single();
        test_fill();
        test_full_push_pop();
        test_rr();
        test_disable();
        intr_en_i = 0;
        step(3'b001, 0, 0, "intr_off");
        intr_en_i = 1;
        drain("intr_drain");
        test_saturate();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
